id_stage: RTL and testbench
===========================

# id_stage

Instruction decode and register-read stage of the RISC-V core. It accepts one 32-bit instruction per handshake, decodes the OP-IMM (I_TYPE) and OP (R_TYPE) formats, and reads two operands from an internal 32×32 register file. It presents `opcodeValid`, `opcode`, `f3`, `imm`, `rs1` and `rs2` to the ALU one cycle after acceptance. It also owns the register-file write port used by writeback.

## Interface
- `D_WIDTH`, 32: operand/data width.
- `REG_ADDR_W`, 5: register index width (32 registers).
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `instrValid` in 1: upstream instruction valid.
- `instr` in 32: instruction word.
- `instrReady` out 1: stage can accept; `instrValid && instrReady` is an accept.
- `aluReady` in 1: ALU consumes the current output this cycle.
- `flush` in 1: discard the held output and do not accept this cycle.
- `wbValid` in 1: writeback request.
- `wbRd` in 5: writeback register index.
- `wbData` in D_WIDTH: writeback data.
- `opcodeValid` out 1: output register holds a legal decoded instruction.
- `opcode` out 7: `instr[6:0]`.
- `f3` out func3: `instr[14:12]`.
- `imm` out 12: `instr[31:20]`. For R_TYPE this is {funct7, rs2 index}, so `imm[10]` selects SUB/SRA.
- `rs1` out D_WIDTH: operand from register `instr[19:15]`.
- `rs2` out D_WIDTH: operand from register `instr[24:20]`.
- `rd` out 5: `instr[11:7]`.
- `illegal` out 1: one-cycle pulse for an accepted undecodable instruction.

## Operation
- The stage is a single output register with valid/ready flow control. `instrReady = !rst && !flush && (!opcodeValid || aluReady)`.
- On accept:
  - Capture all decoded fields and both operand values.
  - Set `opcodeValid` if the instruction is legal, otherwise set `illegal` for one cycle.
- If `opcodeValid && aluReady` and there is no accept, clear `opcodeValid`.
- If `flush` is high, clear `opcodeValid` and `illegal`. Flush takes priority over accept and over hold.
- Legal encodings:
  - Opcode is I_TYPE or R_TYPE.
  - R_TYPE: funct7 is 0000000, or 0100000 only when `f3` is ADD_SUB or SRL_SRA.
  - I_TYPE SLLI: `imm[11:5]` is 0000000.
  - I_TYPE SRLI_SRAI: `imm[11:5]` is 0000000 or 0100000.
  - Any other encoding is illegal.
- Register file:
  - x0 always reads 0. Writes with `wbRd==0` are ignored.
  - A write happens on a clock edge with `wbValid` set.
  - Writeback writes proceed regardless of stall or flush.
- RAW hazards against instructions still in later stages are not detected here. The issue logic upstream guarantees their absence.

## Timing
- Reset (synchronous, while `rst` is high):
  - `opcodeValid`, `illegal`, `opcode`, `f3`, `imm`, `rs1`, `rs2` and `rd` are all 0.
  - All 31 registers clear to 0.
  - `instrReady` is 0; writeback is ignored.
- Latency: accept in cycle N → outputs valid in cycle N+1.
- Throughput: 1 instruction per cycle while `aluReady` is high.
- Stall: while `opcodeValid && !aluReady`, every output holds stable and `instrReady` is 0.
- Simultaneous accept and consume (`aluReady` with a new accept): the output register loads the new instruction, so there is no bubble.
- Reset mid-stall drops the held instruction with no output.
- `illegal` goes high for exactly one cycle after the accept. It does not stall the stage.

## Configuration
- `ID_WB_BYPASS_EN` defined:
  - When a register read index equals `wbRd` (nonzero) with `wbValid` in the accept cycle, the captured operand is `wbData`.
- `ID_WB_BYPASS_EN` undefined:
  - The captured operand is the pre-write register value.
  - The write still lands, and the next read of that register returns `wbData`.

## Structure
- `riscv_pkg` holds:
  - Existing: `I_TYPE`, `R_TYPE`, `func3`, `func7`.
  - New constants: `F7_BASE` (0000000), `F7_ALT` (0100000).
  - New typedef: `id_out_t` for the output bundle.
- Sub-module `reg_file`: 32×D_WIDTH, two combinational read ports, one synchronous write port, synchronous reset, x0 hardwired to 0.
- `id_stage` holds the decode logic, legality check, bypass mux and output register.

## Test plan
- Reset, then write x1=0x11111111 and x2=0xAAAAAAAA via writeback, then send ADD x3,x1,x2 (0x002081B3) → next cycle `opcodeValid`=1, `opcode`=R_TYPE, `f3`=ADD_SUB, `imm[10]`=0, `rs1`=0x11111111, `rs2`=0xAAAAAAAA, `rd`=3.
- SRAI x5,x1,3 (0x4030D293) → `imm`=0x403, `imm[10]`=1, `f3`=SRLI_SRAI. SLLI with funct7=0100000 → `illegal` pulse, `opcodeValid`=0.
- Back-to-back ADDI with `aluReady` low for 3 cycles → outputs frozen and `instrReady`=0. On release, both instructions arrive in order with no loss or duplication.
- Same-cycle `wbValid`, `wbRd`=1, `wbData`=0xDEADBEEF with accept of an instruction reading x1 → `rs1`=0xDEADBEEF with the bypass macro, old value without it.
- Writeback to x0 with 0xFFFFFFFF, then read x0 → `rs1`=0. Opcode 0x37 (LUI) → `illegal`=1 for 1 cycle.
- `flush` while stalled with a held instruction → `opcodeValid`=0 next cycle and nothing issued. Assert `rst` mid-stall → all outputs 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants, output bundle type and the legality check
// used by the decode stage.
package riscv_pkg;

  localparam int DATA_W = 32;

  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] R_TYPE = 7'b0110011;

  typedef enum logic [2:0] {
    ADD_SUB = 3'd0,
    SLL     = 3'd1,
    SLT     = 3'd2,
    SLTU    = 3'd3,
    XOR_OP  = 3'd4,
    SRL_SRA = 3'd5,
    OR_OP   = 3'd6,
    AND_OP  = 3'd7
  } func3;

  localparam func3 SLLI      = SLL;
  localparam func3 SRLI_SRAI = SRL_SRA;

  typedef logic [6:0] func7;

  localparam func7 F7_BASE = 7'b0000000;
  localparam func7 F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic              opcode_valid;
    logic              illegal;
    logic [6:0]        opcode;
    logic [2:0]        f3;
    logic [11:0]       imm;
    logic [DATA_W-1:0] rs1;
    logic [DATA_W-1:0] rs2;
    logic [4:0]        rd;
  } id_out_t;

  // f7 is instr[31:25]: funct7 for R_TYPE, imm[11:5] for I_TYPE shifts.
  function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3,
                                    input logic [6:0] f7);
    logic ok;
    ok = 1'b0;
    if (op == R_TYPE) begin
      ok = (f7 == F7_BASE) ||
           ((f7 == F7_ALT) && ((f3 == ADD_SUB) || (f3 == SRL_SRA)));
    end else if (op == I_TYPE) begin
      if (f3 == SLLI)
        ok = (f7 == F7_BASE);
      else if (f3 == SRLI_SRAI)
        ok = (f7 == F7_BASE) || (f7 == F7_ALT);
      else
        ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/id_stage_reg_file.sv
// 32-entry register file: two combinational read ports, one synchronous
// write port, synchronous reset, x0 hardwired to zero.
module reg_file
  import riscv_pkg::*;
#(
  parameter int D_WIDTH    = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] raddr1,
  input  logic [REG_ADDR_W-1:0] raddr2,
  output logic [D_WIDTH-1:0]    rdata1,
  output logic [D_WIDTH-1:0]    rdata2,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [D_WIDTH-1:0]    wdata
);

  localparam int NREGS = 2 ** REG_ADDR_W;

  logic [D_WIDTH-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/id_stage.sv
// Decode/register-read stage: decodes OP and OP-IMM, reads two operands and
// holds them in a valid/ready output register. Optional: ID_WB_BYPASS_EN.
module id_stage
  import riscv_pkg::*;
#(
  parameter int D_WIDTH    = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instrValid,
  input  logic [31:0]           instr,
  output logic                  instrReady,
  input  logic                  aluReady,
  input  logic                  flush,
  input  logic                  wbValid,
  input  logic [REG_ADDR_W-1:0] wbRd,
  input  logic [D_WIDTH-1:0]    wbData,
  output logic                  opcodeValid,
  output logic [6:0]            opcode,
  output logic [2:0]            f3,
  output logic [11:0]           imm,
  output logic [D_WIDTH-1:0]    rs1,
  output logic [D_WIDTH-1:0]    rs2,
  output logic [4:0]            rd,
  output logic                  illegal
);

  id_out_t            out_q;
  logic               accept;
  logic               legal;
  logic [D_WIDTH-1:0] rf_data1;
  logic [D_WIDTH-1:0] rf_data2;
  logic [D_WIDTH-1:0] op1;
  logic [D_WIDTH-1:0] op2;

  reg_file #(
    .D_WIDTH   (D_WIDTH),
    .REG_ADDR_W(REG_ADDR_W)
  ) u_reg_file (
    .clk   (clk),
    .rst   (rst),
    .raddr1(instr[15 +: REG_ADDR_W]),
    .raddr2(instr[20 +: REG_ADDR_W]),
    .rdata1(rf_data1),
    .rdata2(rf_data2),
    .we    (wbValid),
    .waddr (wbRd),
    .wdata (wbData)
  );

`ifdef ID_WB_BYPASS_EN
  // A same-cycle writeback to a source register forwards its data.
  assign op1 = (wbValid && (wbRd != '0) && (wbRd == instr[15 +: REG_ADDR_W]))
               ? wbData : rf_data1;
  assign op2 = (wbValid && (wbRd != '0) && (wbRd == instr[20 +: REG_ADDR_W]))
               ? wbData : rf_data2;
`else
  assign op1 = rf_data1;
  assign op2 = rf_data2;
`endif

  assign instrReady = !rst && !flush && (!out_q.opcode_valid || aluReady);
  assign accept     = instrValid && instrReady;
  assign legal      = is_legal(instr[6:0], instr[14:12], instr[31:25]);

  // Flush beats accept; fields other than the flags hold across flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else if (flush) begin
      out_q.opcode_valid <= 1'b0;
      out_q.illegal      <= 1'b0;
    end else if (accept) begin
      out_q.opcode_valid <= legal;
      out_q.illegal      <= !legal;
      out_q.opcode       <= instr[6:0];
      out_q.f3           <= instr[14:12];
      out_q.imm          <= instr[31:20];
      out_q.rs1          <= op1;
      out_q.rs2          <= op2;
      out_q.rd           <= instr[11:7];
    end else begin
      out_q.illegal <= 1'b0;
      if (out_q.opcode_valid && aluReady)
        out_q.opcode_valid <= 1'b0;
    end
  end

  assign opcodeValid = out_q.opcode_valid;
  assign illegal     = out_q.illegal;
  assign opcode      = out_q.opcode;
  assign f3          = out_q.f3;
  assign imm         = out_q.imm;
  assign rs1         = out_q.rs1;
  assign rs2         = out_q.rs2;
  assign rd          = out_q.rd;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios followed by random
// traffic, all compared cycle by cycle against a behavioural model.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_ready;
  logic        alu_ready = 1'b1;
  logic        flush = 1'b0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        opcode_valid;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [11:0] imm;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [4:0]  rd;
  logic        illegal;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state: architectural registers plus the visible output.
  logic [31:0] m_regs [32];
  logic        m_valid = 0, m_illegal = 0;
  logic [31:0] m_instr = 0;
  logic [31:0] m_rs1 = 0, m_rs2 = 0;

  id_stage dut (
    .clk(clk), .rst(rst), .instrValid(instr_valid), .instr(instr),
    .instrReady(instr_ready), .aluReady(alu_ready), .flush(flush),
    .wbValid(wb_valid), .wbRd(wb_rd), .wbData(wb_data),
    .opcodeValid(opcode_valid), .opcode(opcode), .f3(f3), .imm(imm),
    .rs1(rs1), .rs2(rs2), .rd(rd), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Legal iff one of the enumerated legal shapes of OP / OP-IMM.
  function automatic bit ref_legal(input logic [31:0] w);
    int op, fn3, top7;
    op = w[6:0]; fn3 = w[14:12]; top7 = w[31:25];
    if (op == 'h33) return (top7 == 0) || (top7 == 'h20 && (fn3 == 0 || fn3 == 5));
    if (op == 'h13) begin
      if (fn3 == 1) return top7 == 0;
      if (fn3 == 5) return top7 == 0 || top7 == 'h20;
      return 1;
    end
    return 0;
  endfunction

  function automatic logic [31:0] read_operand(input int idx);
    if (idx == 0) return 0;
`ifdef ID_WB_BYPASS_EN
    if (wb_valid && wb_rd == idx) return wb_data;
`endif
    return m_regs[idx];
  endfunction

  function automatic bit model_ready();
    return !rst && !flush && (!m_valid || alu_ready);
  endfunction

  task automatic modelStep();
    bit take;
    take = instr_valid && model_ready();
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = 0;
      m_valid = 0; m_illegal = 0; m_instr = 0; m_rs1 = 0; m_rs2 = 0;
      return;
    end
    if (flush) begin
      m_valid = 0; m_illegal = 0;
    end else if (take) begin
      m_instr   = instr;
      m_rs1     = read_operand(instr[19:15]);
      m_rs2     = read_operand(instr[24:20]);
      m_valid   = ref_legal(instr);
      m_illegal = !ref_legal(instr);
    end else begin
      m_illegal = 0;
      if (alu_ready) m_valid = 0;
    end
    if (wb_valid && wb_rd != 0) m_regs[wb_rd] = wb_data;
  endtask

  task automatic applyStimulus(input bit r, input bit iv, input logic [31:0] ins,
                               input bit ar, input bit fl, input bit wv,
                               input logic [4:0] wr, input logic [31:0] wd);
    @(negedge clk);
    rst = r; instr_valid = iv; instr = ins; alu_ready = ar; flush = fl;
    wb_valid = wv; wb_rd = wr; wb_data = wd;
    #1;
    checkOutput("instrReady", {31'b0, instr_ready}, {31'b0, model_ready()});
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("opcodeValid", {31'b0, opcode_valid}, {31'b0, m_valid});
    checkOutput("illegal", {31'b0, illegal}, {31'b0, m_illegal});
    checkOutput("opcode", {25'b0, opcode}, {25'b0, m_instr[6:0]});
    checkOutput("f3", {29'b0, f3}, {29'b0, m_instr[14:12]});
    checkOutput("imm", {20'b0, imm}, {20'b0, m_instr[31:20]});
    checkOutput("rs1", rs1, m_rs1);
    checkOutput("rs2", rs2, m_rs2);
    checkOutput("rd", {27'b0, rd}, {27'b0, m_instr[11:7]});
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  top;
    w = $urandom;
    case ($urandom_range(0, 2))
      0: top = 7'h00;
      1: top = 7'h20;
      default: top = 7'($urandom);
    endcase
    case ($urandom_range(0, 3))
      0: w = {top, w[24:7], 7'h33};
      1: w = {top, w[24:7], 7'h13};
      2: w = {w[31:7], 7'h13};
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    foreach (m_regs[i]) m_regs[i] = 0;
    applyStimulus(1, 0, 0, 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, 0, 0, 0);
    checkOutput("reset_valid", {31'b0, opcode_valid}, 32'd0);

    applyStimulus(0, 0, 0, 1, 0, 1, 1, 32'h11111111);
    applyStimulus(0, 0, 0, 1, 0, 1, 2, 32'hAAAAAAAA);
    applyStimulus(0, 1, 32'h002081B3, 1, 0, 0, 0, 0);
    checkOutput("add_rs1", rs1, 32'h11111111);
    checkOutput("add_rs2", rs2, 32'hAAAAAAAA);
    checkOutput("add_rd", {27'b0, rd}, 32'd3);
    checkOutput("add_imm10", {31'b0, imm[10]}, 32'd0);

    applyStimulus(0, 1, 32'h4030D293, 1, 0, 0, 0, 0);
    checkOutput("srai_imm", {20'b0, imm}, 32'h403);
    applyStimulus(0, 1, 32'h40309293, 1, 0, 0, 0, 0);
    checkOutput("slli_bad_illegal", {31'b0, illegal}, 32'd1);
    checkOutput("slli_bad_valid", {31'b0, opcode_valid}, 32'd0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);

    // Two ADDIs separated by a three-cycle ALU stall.
    applyStimulus(0, 1, 32'h00508313, 1, 0, 0, 0, 0);
    repeat (3) applyStimulus(0, 1, 32'h00110393, 0, 0, 0, 0, 0);
    checkOutput("stall_rd", {27'b0, rd}, 32'd6);
    applyStimulus(0, 1, 32'h00110393, 1, 0, 0, 0, 0);
    checkOutput("release_rd", {27'b0, rd}, 32'd7);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);

    applyStimulus(0, 1, 32'h002081B3, 1, 0, 1, 1, 32'hDEADBEEF);
`ifdef ID_WB_BYPASS_EN
    checkOutput("bypass_rs1", rs1, 32'hDEADBEEF);
`else
    checkOutput("bypass_rs1", rs1, 32'h11111111);
`endif
    applyStimulus(0, 1, 32'h002081B3, 1, 0, 0, 0, 0);
    checkOutput("after_wb_rs1", rs1, 32'hDEADBEEF);

    applyStimulus(0, 0, 0, 1, 0, 1, 0, 32'hFFFFFFFF);
    applyStimulus(0, 1, 32'h00000413, 1, 0, 0, 0, 0);
    checkOutput("x0_rs1", rs1, 32'd0);
    applyStimulus(0, 1, 32'h000000B7, 1, 0, 0, 0, 0);
    checkOutput("lui_illegal", {31'b0, illegal}, 32'd1);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
    checkOutput("lui_pulse_end", {31'b0, illegal}, 32'd0);

    applyStimulus(0, 1, 32'h00508313, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'h00110393, 0, 1, 0, 0, 0);
    checkOutput("flush_valid", {31'b0, opcode_valid}, 32'd0);
    applyStimulus(0, 1, 32'h00508313, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_stall_rs1", rs1, 32'd0);

    for (int n = 0; n < 1500; n++)
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, rand_instr(),
                    $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                    $urandom_range(0, 1) == 1, 5'($urandom), $urandom);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
